// File: rtl/alu_pkg.sv
// Shared definitions for the SIMD ALU output stage.
// Mode encodings, default lane geometry and the lane-slice type.
package alu_pkg;

  // USE_SIMD encodings
  localparam logic MODE_16X16   = 1'b0;
  localparam logic MODE_SUM_8X8 = 1'b1;

  // Default lane geometry
  localparam int LANE_W = 16;
  localparam int LANES  = 2;

  // One lane's worth of datapath bits
  typedef logic [LANE_W-1:0] lane_t;

endpackage : alu_pkg

// File: rtl/pattern_detect_lane.sv
// Combinational masked pattern / inverted-pattern compare for one lane.
// A MASK bit of 1 removes that bit from both compares.
// A fully masked lane therefore reports both matches.
module pattern_detect_lane
  import alu_pkg::*;
#(
  parameter int LW = LANE_W
) (
  input  logic [LW-1:0] i_s,
  input  logic [LW-1:0] i_pattern,
  input  logic [LW-1:0] i_mask,
  output logic          o_m,
  output logic          o_mb
);

  logic [LW-1:0] w_eq;
  logic [LW-1:0] w_eqb;

  // Per-bit agreement with PATTERN and ~PATTERN; masked bits always agree
  always_comb begin
    w_eq  = ~(i_s ^ i_pattern) | i_mask;
    w_eqb = (i_s ^ i_pattern) | i_mask;
    o_m   = &w_eq;
    o_mb  = &w_eqb;
  end

endmodule : pattern_detect_lane

// File: rtl/alu_p_register_stage.sv
// P register stage downstream of the 2-lane SIMD ALU.
// Registers the ALU sum and lane carries, performs per-lane masked pattern
// detection with one load of history, and derives OVERFLOW / UNDERFLOW.
// Optional feature: define ALU_PSTAGE_AUTORESET_EN to add the
// AUTORESET_PATDET input, which clears P on a full pattern match.
module alu_p_register_stage #(
  parameter int WIDTH  = 32,
  parameter int LANES  = alu_pkg::LANES,
  parameter int LANE_W = alu_pkg::LANE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CEP,
  input  logic             RSTP,
  input  logic             USE_SIMD,
  input  logic [WIDTH-1:0] S,
  input  logic [LANES-1:0] result_SIMD_carry_out,
  input  logic [WIDTH-1:0] PATTERN,
  input  logic [WIDTH-1:0] MASK,
`ifdef ALU_PSTAGE_AUTORESET_EN
  input  logic             AUTORESET_PATDET,
`endif
  output logic [WIDTH-1:0] P,
  output logic [LANES-1:0] CARRYOUT,
  output logic [LANES-1:0] PATTERNDETECT,
  output logic [LANES-1:0] PATTERNBDETECT,
  output logic [LANES-1:0] PATTERNDETECTPAST,
  output logic [LANES-1:0] PATTERNBDETECTPAST,
  output logic [LANES-1:0] OVERFLOW,
  output logic [LANES-1:0] UNDERFLOW
);

  import alu_pkg::*;

  logic [LANES-1:0] w_m;
  logic [LANES-1:0] w_mb;
  logic [LANES-1:0] w_det;
  logic [LANES-1:0] w_detb;
  logic             w_autoreset;

  logic [WIDTH-1:0] r_p;
  logic [LANES-1:0] r_carry;
  logic [LANES-1:0] r_pd;
  logic [LANES-1:0] r_pbd;
  logic [LANES-1:0] r_pdp;
  logic [LANES-1:0] r_pbdp;

  // One compare unit per lane
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      pattern_detect_lane #(
        .LW (LANE_W)
      ) u_lane (
        .i_s       (S[gi*LANE_W +: LANE_W]),
        .i_pattern (PATTERN[gi*LANE_W +: LANE_W]),
        .i_mask    (MASK[gi*LANE_W +: LANE_W]),
        .o_m       (w_m[gi]),
        .o_mb      (w_mb[gi])
      );
    end
  endgenerate

  // Mode merge: full-width mode broadcasts the all-lane AND to every lane
  always_comb begin
    if (USE_SIMD == MODE_SUM_8X8) begin
      w_det  = w_m;
      w_detb = w_mb;
    end else begin
      w_det  = {LANES{&w_m}};
      w_detb = {LANES{&w_mb}};
    end
  end

`ifdef ALU_PSTAGE_AUTORESET_EN
  // Auto-reset fires when every lane currently reports a match
  always_comb begin
    if (AUTORESET_PATDET && CEP && (&r_pd)) begin
      w_autoreset = 1'b1;
    end else begin
      w_autoreset = 1'b0;
    end
  end
`else
  // Auto-reset feature not built
  always_comb begin
    w_autoreset = 1'b0;
  end
`endif

  // P, carry and detect registers: reset > RSTP > auto-reset > load > hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p     <= {WIDTH{1'b0}};
      r_carry <= {LANES{1'b0}};
      r_pd    <= {LANES{1'b0}};
      r_pbd   <= {LANES{1'b0}};
      r_pdp   <= {LANES{1'b0}};
      r_pbdp  <= {LANES{1'b0}};
    end else if (RSTP) begin
      r_p     <= {WIDTH{1'b0}};
      r_carry <= {LANES{1'b0}};
      r_pd    <= {LANES{1'b0}};
      r_pbd   <= {LANES{1'b0}};
      r_pdp   <= {LANES{1'b0}};
      r_pbdp  <= {LANES{1'b0}};
    end else if (w_autoreset) begin
      // History still advances so the flags survive the clear
      r_p     <= {WIDTH{1'b0}};
      r_carry <= {LANES{1'b0}};
      r_pd    <= {LANES{1'b0}};
      r_pbd   <= {LANES{1'b0}};
      r_pdp   <= r_pd;
      r_pbdp  <= r_pbd;
    end else if (CEP) begin
      r_p     <= S;
      r_carry <= result_SIMD_carry_out;
      r_pd    <= w_det;
      r_pbd   <= w_detb;
      r_pdp   <= r_pd;
      r_pbdp  <= r_pbd;
    end else begin
      r_p     <= r_p;
      r_carry <= r_carry;
      r_pd    <= r_pd;
      r_pbd   <= r_pbd;
      r_pdp   <= r_pdp;
      r_pbdp  <= r_pbdp;
    end
  end

  // Outputs straight from registers; flags are a thin decode of them
  always_comb begin
    P                  = r_p;
    CARRYOUT           = r_carry;
    PATTERNDETECT      = r_pd;
    PATTERNBDETECT     = r_pbd;
    PATTERNDETECTPAST  = r_pdp;
    PATTERNBDETECTPAST = r_pbdp;
    OVERFLOW           = r_pdp  & ~r_pd & ~r_pbd;
    UNDERFLOW          = r_pbdp & ~r_pd & ~r_pbd;
  end

endmodule : alu_p_register_stage

// File: tb/tb_alu_p_register_stage.sv
// Directed self-checking bench for alu_p_register_stage.
// Covers reset, full-width and SIMD detect, overflow/underflow, enable hold,
// sync clear, async mid-run reset and (when ALU_PSTAGE_AUTORESET_EN is
// defined) auto-reset.
module tb_alu_p_register_stage;

  logic        clk;
  logic        rst_n;
  logic        cep;
  logic        rstp;
  logic        use_simd;
  logic [31:0] s;
  logic [1:0]  cy;
  logic [31:0] pattern;
  logic [31:0] mask;
`ifdef ALU_PSTAGE_AUTORESET_EN
  logic        autoreset;
`endif
  logic [31:0] p;
  logic [1:0]  carryout;
  logic [1:0]  pd;
  logic [1:0]  pbd;
  logic [1:0]  pdp;
  logic [1:0]  pbdp;
  logic [1:0]  ovf;
  logic [1:0]  udf;

  int n_checks = 0;
  int n_fails  = 0;

  alu_p_register_stage #(
    .WIDTH  (32),
    .LANES  (2),
    .LANE_W (16)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .CEP                   (cep),
    .RSTP                  (rstp),
    .USE_SIMD              (use_simd),
    .S                     (s),
    .result_SIMD_carry_out (cy),
    .PATTERN               (pattern),
    .MASK                  (mask),
`ifdef ALU_PSTAGE_AUTORESET_EN
    .AUTORESET_PATDET      (autoreset),
`endif
    .P                     (p),
    .CARRYOUT              (carryout),
    .PATTERNDETECT         (pd),
    .PATTERNBDETECT        (pbd),
    .PATTERNDETECTPAST     (pdp),
    .PATTERNBDETECTPAST    (pbdp),
    .OVERFLOW              (ovf),
    .UNDERFLOW             (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    cep      = 1'b1;
    rstp     = 1'b0;
    use_simd = 1'b0;
    s        = 32'hFFFF_FFFF;
    cy       = 2'b11;
    pattern  = 32'h0000_0000;
    mask     = 32'h0000_0000;
`ifdef ALU_PSTAGE_AUTORESET_EN
    autoreset = 1'b0;
`endif

    // Reset held with clocks running
    repeat (3) tick();
    chk("rst_p",    p,         32'h0);
    chk("rst_cy",   {30'h0, carryout}, 32'h0);
    chk("rst_pd",   {30'h0, pd},   32'h0);
    chk("rst_pbd",  {30'h0, pbd},  32'h0);
    chk("rst_pdp",  {30'h0, pdp},  32'h0);
    chk("rst_ovf",  {30'h0, ovf},  32'h0);
    chk("rst_udf",  {30'h0, udf},  32'h0);

    // Release, first load
    rst_n = 1'b1;
    tick();
    chk("rel_p",   p, 32'hFFFF_FFFF);
    chk("rel_cy",  {30'h0, carryout}, 32'h3);
    chk("rel_pbd", {30'h0, pbd}, 32'h3);
    chk("rel_pd",  {30'h0, pd},  32'h0);

    // Full-width match
    pattern = 32'h0000_1234;
    s       = 32'h0000_1234;
    cy      = 2'b10;
    tick();
    chk("fw_pd",   {30'h0, pd},   32'h3);
    chk("fw_pbd",  {30'h0, pbd},  32'h0);
    chk("fw_cy",   {30'h0, carryout}, 32'h2);
    chk("fw_pbdp", {30'h0, pbdp}, 32'h3);
    chk("fw_udf",  {30'h0, udf},  32'h0);

    // Full-width inverted match
    s = 32'hFFFF_EDCB;
    tick();
    chk("fwb_pbd", {30'h0, pbd}, 32'h3);
    chk("fwb_pd",  {30'h0, pd},  32'h0);
    chk("fwb_pdp", {30'h0, pdp}, 32'h3);
    chk("fwb_ovf", {30'h0, ovf}, 32'h0);

    // SIMD lanes: only lane 0 matches zero
    use_simd = 1'b1;
    pattern  = 32'h0000_0000;
    s        = 32'h0005_0000;
    tick();
    chk("simd_pd",  {30'h0, pd},  32'h1);
    chk("simd_pbd", {30'h0, pbd}, 32'h0);
    chk("simd_udf", {30'h0, udf}, 32'h2);

    // Overflow sequence
    mask     = 32'h0000_7FFF;
    use_simd = 1'b0;
    s        = 32'h0000_7FF0;
    tick();
    chk("ov1_pd", {30'h0, pd}, 32'h3);
    s = 32'h0000_8001;
    tick();
    chk("ov2_ovf", {30'h0, ovf}, 32'h3);
    chk("ov2_udf", {30'h0, udf}, 32'h0);
    chk("ov2_pd",  {30'h0, pd},  32'h0);

    // Enable low: everything holds, mode change not applied
    cep = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s        = 32'h1111_0000 + i;
      use_simd = ~use_simd;
      tick();
    end
    chk("hold_p",   p, 32'h0000_8001);
    chk("hold_ovf", {30'h0, ovf}, 32'h3);
    chk("hold_pdp", {30'h0, pdp}, 32'h3);

    // Sync clear beats enable
    cep  = 1'b1;
    rstp = 1'b1;
    s    = 32'h1234_5678;
    tick();
    chk("rstp_p",   p, 32'h0);
    chk("rstp_cy",  {30'h0, carryout}, 32'h0);
    chk("rstp_pdp", {30'h0, pdp}, 32'h0);
    chk("rstp_ovf", {30'h0, ovf}, 32'h0);
    rstp = 1'b0;

    // Async reset mid-operation
    use_simd = 1'b0;
    s  = 32'hA5A5_5A5A;
    cy = 2'b01;
    tick();
    chk("async_pre", p, 32'hA5A5_5A5A);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_p",  p, 32'h0);
    chk("async_cy", {30'h0, carryout}, 32'h0);
    rst_n = 1'b1;
    s = 32'h0BAD_F00D;
    tick();
    chk("async_rel", p, 32'h0BAD_F00D);

`ifdef ALU_PSTAGE_AUTORESET_EN
    // Auto-reset on full pattern match
    rstp = 1'b1;
    tick();
    rstp      = 1'b0;
    autoreset = 1'b1;
    pattern   = 32'h0000_0010;
    mask      = 32'h0000_0000;
    s         = 32'h0000_0008;
    tick();
    chk("ar_8_pd", {30'h0, pd}, 32'h0);
    s = 32'h0000_0010;
    tick();
    chk("ar_16_pd", {30'h0, pd}, 32'h3);
    chk("ar_16_p",  p, 32'h0000_0010);
    s = 32'h0000_0018;
    tick();
    chk("ar_clr_p",   p, 32'h0);
    chk("ar_clr_pd",  {30'h0, pd},  32'h0);
    chk("ar_clr_pdp", {30'h0, pdp}, 32'h3);
    autoreset = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_alu_p_register_stage
